// File: rtl/eth_stream_pkg.sv
// eth_stream_pkg: shared types and helpers for the eth-stream receive path
package eth_stream_pkg;
   localparam int FCS_BYTES_DEFAULT = 4;
   typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;
   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  keep;
      logic        last;
      logic        abort;
   } eth_beat_t;
   function automatic int keep_to_bytes(input int keep);
      return keep + 1;
   endfunction
   function automatic int bytes_to_keep(input int n);
      return n - 1;
   endfunction
endpackage

// File: rtl/eth_fcs_extract.sv
// eth_fcs_extract: picks the trailing FCS bytes out of {input beat, held beat}
module eth_fcs_extract
   import eth_stream_pkg::*;
#(
   parameter int BYTES     = 4,
   parameter int FCS_BYTES = FCS_BYTES_DEFAULT,
   parameter int KW        = $clog2(BYTES)
) (
   input  logic [8*BYTES-1:0] i_hold_data,
   input  logic [8*BYTES-1:0] i_data,
   input  logic [KW-1:0]      i_keep,
   output logic [31:0]        o_fcs
);
   localparam logic [31:0] FCS_MASK = 32'((64'd1 << (8 * FCS_BYTES)) - 64'd1);
   // The FCS ends at input byte n-1, so it starts BYTES+n-FCS_BYTES bytes into the pair
   always_comb
      o_fcs = 32'({i_data, i_hold_data} >> (8 * (BYTES + keep_to_bytes(int'(i_keep)) - FCS_BYTES))) & FCS_MASK;
endmodule

// File: rtl/eth_rx_fcs_strip.sv
// eth_rx_fcs_strip: strips the 4-byte FCS tail from each frame and exports it
module eth_rx_fcs_strip
   import eth_stream_pkg::*;
#(
   parameter  int DATAPATH_WIDTH = 32,
   parameter  int FCS_BYTES      = FCS_BYTES_DEFAULT,
   localparam int BYTES          = DATAPATH_WIDTH / 8,
   localparam int KW             = $clog2(BYTES)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [DATAPATH_WIDTH-1:0] i_eths_slave_data,
   input  logic [KW-1:0]             i_eths_slave_keep,
   input  logic                      i_eths_slave_valid,
   input  logic                      i_eths_slave_abort,
   input  logic                      i_eths_slave_last,
   output logic [DATAPATH_WIDTH-1:0] o_eths_master_data,
   output logic [KW-1:0]             o_eths_master_keep,
   output logic                      o_eths_master_valid,
   output logic                      o_eths_master_abort,
   output logic                      o_eths_master_last,
   output logic [31:0]               o_fcs,
   output logic                      o_fcs_valid
);
   localparam logic [KW-1:0] KEEP_FULL = KW'(BYTES - 1);
   localparam logic [KW-1:0] KEEP_BASE = KW'(BYTES - FCS_BYTES);

   if ((DATAPATH_WIDTH != 32 && DATAPATH_WIDTH != 64) || FCS_BYTES < 1 || FCS_BYTES > BYTES || FCS_BYTES > 4) begin : g_param_check
      $error("eth_rx_fcs_strip: illegal DATAPATH_WIDTH/FCS_BYTES combination");
   end

   state_t                    state;
   logic [DATAPATH_WIDTH-1:0] hold_data;
   logic [DATAPATH_WIDTH-1:0] tail_data;
   logic [KW-1:0]             tail_keep;
   logic [31:0]               fcs_pend;
   logic [31:0]               fcs_ext;
   int                        in_bytes;
   logic                      runt;

   assign in_bytes = keep_to_bytes(int'(i_eths_slave_keep));
   assign runt     = in_bytes <= FCS_BYTES;

   eth_fcs_extract #(.BYTES(BYTES), .FCS_BYTES(FCS_BYTES), .KW(KW)) u_fcs_extract (
      .i_hold_data (hold_data),
      .i_data      (i_eths_slave_data),
      .i_keep      (i_eths_slave_keep),
      .o_fcs       (fcs_ext)
   );

   // Strip FSM: later assignments override the FLUSH tail emission (abort/runt win the output slot)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state               <= IDLE;
         hold_data           <= '0;
         tail_data           <= '0;
         tail_keep           <= '0;
         fcs_pend            <= '0;
         o_eths_master_data  <= '0;
         o_eths_master_keep  <= '0;
         o_eths_master_valid <= 1'b0;
         o_eths_master_abort <= 1'b0;
         o_eths_master_last  <= 1'b0;
         o_fcs               <= '0;
         o_fcs_valid         <= 1'b0;
      end else begin
         o_eths_master_valid <= 1'b0;
         o_eths_master_abort <= 1'b0;
         o_eths_master_last  <= 1'b0;
         o_fcs_valid         <= 1'b0;
         if (state == FLUSH) begin
            o_eths_master_valid <= 1'b1;
            o_eths_master_data  <= tail_data;
            o_eths_master_keep  <= tail_keep;
            o_eths_master_last  <= 1'b1;
            o_fcs               <= fcs_pend;
            o_fcs_valid         <= 1'b1;
            state               <= IDLE;
         end
         if (i_eths_slave_valid) begin
            if (i_eths_slave_abort) begin
               o_eths_master_valid <= 1'b1;
               o_eths_master_last  <= 1'b1;
               o_eths_master_abort <= 1'b1;
               o_eths_master_keep  <= '0;
               o_fcs_valid         <= 1'b0;
               state               <= IDLE;
            end else if (state == HOLD) begin
               o_eths_master_valid <= 1'b1;
               o_eths_master_data  <= hold_data;
               o_eths_master_keep  <= KEEP_FULL;
               if (!i_eths_slave_last) begin
                  hold_data <= i_eths_slave_data;
               end else if (runt) begin
                  o_eths_master_last <= 1'b1;
                  o_eths_master_keep <= KEEP_BASE + i_eths_slave_keep;
                  o_fcs              <= fcs_ext;
                  o_fcs_valid        <= 1'b1;
                  state              <= IDLE;
               end else begin
                  tail_data <= i_eths_slave_data;
                  tail_keep <= KW'(bytes_to_keep(in_bytes - FCS_BYTES));
                  fcs_pend  <= fcs_ext;
                  state     <= FLUSH;
               end
            end else if (!i_eths_slave_last) begin
               hold_data <= i_eths_slave_data;
               state     <= HOLD;
            end else if (runt) begin
               o_eths_master_valid <= 1'b1;
               o_eths_master_last  <= 1'b1;
               o_eths_master_abort <= 1'b1;
               o_eths_master_keep  <= '0;
               o_fcs_valid         <= 1'b0;
            end else begin
               tail_data <= i_eths_slave_data;
               tail_keep <= KW'(bytes_to_keep(in_bytes - FCS_BYTES));
               fcs_pend  <= fcs_ext;
               state     <= FLUSH;
            end
         end
      end
   end
endmodule
